edc_check_pipe: RTL and testbench
=================================

Name: edc_check_pipe

Overview:
- Pipelined, parametrised SEC-DED check/correct stage for the memory read path.
- Accepts NUM_LANES words per beat, each 32 data bits plus the 8 stored check bits.
- Regenerates the (40,32) check bits, forms syndromes, corrects single-bit errors and flags double-bit errors.
- Keeps saturating error counters and a first-uncorrectable-error log; sits between the memory read port and the cache/bus read-data mux.

Parameters:
NUM_LANES, 1, number of independent 32-bit lanes per beat (1..8)
ADDR_W, 32, width of the address tag carried with each beat
CNT_W, 16, width of each saturating error counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept input beat
i_addr  in  ADDR_W  address tag of beat
i_data  in  32*NUM_LANES  raw data, lane n at [32n+31:32n]
i_ecc  in  8*NUM_LANES  stored check bits, lane n at [8n+7:8n]
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts output beat
o_addr  out  ADDR_W  address tag, passed through
o_data  out  32*NUM_LANES  corrected data
o_err_lane  out  NUM_LANES  per-lane syndrome nonzero
o_unc_lane  out  NUM_LANES  per-lane uncorrectable
i_cnt_clr  in  1  single-cycle clear of counters and log
o_ce_count  out  CNT_W  corrected-error count, saturating
o_ue_count  out  CNT_W  uncorrectable-error count, saturating
o_log_valid  out  1  log holds an uncorrectable event
o_log_addr  out  ADDR_W  address of first logged event
o_log_lane  out  3  lane index of first logged event (lowest failing lane)
o_log_syndrome  out  8  syndrome of logged lane

Behaviour:
- Reset (async assert, sync deassert by the system): all valids, counters, log fields and stage registers are 0; o_ready is 1 after reset.
- Stage 1 registers: addr, data, and syndrome = generated ECC XOR i_ecc per lane.
  - Generated check bit k = XOR of the data bits whose H column has bit k set.
- Stage 2 registers: corrected data plus per-lane flags.
- Latency: exactly 2 cycles from input handshake to o_valid with no stalls. Full throughput is 1 beat/cycle.
- Handshake:
  - adv2 = !o_valid | i_ready; adv1 = !s1_valid | adv2; o_ready = adv1 (combinational).
  - A stalled stage holds all of its fields stable.
- Per-lane decode, with syndrome s:
  - s==0: no error.
  - s equals a data column (all weight 3): flip that data bit; correctable.
  - s has weight 1: check-bit error; data unchanged; correctable.
  - Any other nonzero s: uncorrectable; data passed raw; o_unc_lane set.
- Counters update on the output handshake (o_valid & i_ready):
  - o_ce_count += number of correctable lanes; o_ue_count += number of uncorrectable lanes.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
- Log: on the first output handshake with any uncorrectable lane while o_log_valid==0, capture addr, the lowest failing lane and its syndrome, and set o_log_valid. Later events do not overwrite the log.
- i_cnt_clr zeroes both counters and o_log_valid on the next edge. If it coincides with an increment or log capture, clear wins and that beat's events are dropped.
- Pipeline contents are unaffected by i_cnt_clr. Reset mid-stream discards all in-flight beats.

Optional Feature:
- Macro: EDC_SCRUB_EN.
- With it defined:
  - Add ports o_scrub_valid, i_scrub_ready, o_scrub_addr, o_scrub_data, o_scrub_ovf.
  - A one-entry buffer loads addr and corrected data on an output handshake with >=1 correctable lane and no uncorrectable lane.
  - The buffer holds until i_scrub_ready; the writer re-stores the corrected data.
  - If the buffer is full and a new qualifying beat arrives, that beat is dropped and o_scrub_ovf is set. o_scrub_ovf is sticky and cleared by i_cnt_clr.
  - The scrub path never stalls the main pipeline.
- Without it: none of these ports or that logic exist.

Decomposition:
- Package edc_pkg:
  - H-matrix column constants for the 32 data bits.
  - ECC_W=8, DATA_W=32.
  - Syndrome-class encoding {NONE, CORR_DATA, CORR_CHK, UNCORR}.
- Sub-module edc_lane_decode: combinational; syndrome -> error vector + class.
  - Instantiated NUM_LANES times in stage 2.
  - Shared check-bit generator function lives in edc_pkg.

Test Plan:
- NUM_LANES=2, clean beats (ECC from edc_pkg generator) back-to-back, i_ready=1:
  - o_valid 2 cycles after each input, data unchanged, counts stay 0.
- Lane 1 data bit 17 flipped, addr 0x1000:
  - o_data lane 1 corrected, o_err_lane=2'b10, o_unc_lane=0, o_ce_count=1.
- Lane 0 bits 3 and 9 flipped, addr 0x2040, followed by a second double error at 0x3000:
  - o_unc_lane=2'b01, o_ue_count=2, log holds addr 0x2040, lane 0, syndrome of the first event.
- Check bit 4 of lane 0 flipped: data unchanged, counted correctable.
- Hold i_ready=0 for 5 cycles with 3 beats offered:
  - o_ready drops after 2 beats, no beat lost or duplicated, outputs stable while stalled.
- CNT_W=2, 5 single-bit errors:
  - o_ce_count saturates at 3.
  - i_cnt_clr asserted together with a 6th error gives count 0.

Source files
------------

// File: rtl/edc_pkg.sv
// edc_pkg -- shared definitions for the (40,32) SEC-DED check/correct path.
//
// Contents:
//   DATA_W / ECC_W  : data and check-bit widths of one lane
//   syn_class_e     : decode class of a lane syndrome
//   h_col()         : H-matrix column (check-bit pattern) of each data bit
//   gen_ecc()       : check-bit generator shared by the decoder and by anyone
//                     producing clean reference words
//
// The 32 data columns are the first 32 distinct weight-3 patterns of 8 bits in
// ascending order. Check bit k owns the weight-1 column (1 << k). With every
// data column of odd weight 3, any double error leaves an even-weight nonzero
// syndrome, which can never alias a single-error column.
package edc_pkg;

  localparam int DATA_W = 32;
  localparam int ECC_W  = 8;

  typedef enum logic [1:0] {
    CLS_NONE      = 2'd0,
    CLS_CORR_DATA = 2'd1,
    CLS_CORR_CHK  = 2'd2,
    CLS_UNCORR    = 2'd3
  } syn_class_e;

  function automatic logic [ECC_W-1:0] h_col(input int idx);
    logic [ECC_W-1:0] col;
    case (idx)
      0:  col = 8'h07;
      1:  col = 8'h0B;
      2:  col = 8'h0D;
      3:  col = 8'h0E;
      4:  col = 8'h13;
      5:  col = 8'h15;
      6:  col = 8'h16;
      7:  col = 8'h19;
      8:  col = 8'h1A;
      9:  col = 8'h1C;
      10: col = 8'h23;
      11: col = 8'h25;
      12: col = 8'h26;
      13: col = 8'h29;
      14: col = 8'h2A;
      15: col = 8'h2C;
      16: col = 8'h31;
      17: col = 8'h32;
      18: col = 8'h34;
      19: col = 8'h38;
      20: col = 8'h43;
      21: col = 8'h45;
      22: col = 8'h46;
      23: col = 8'h49;
      24: col = 8'h4A;
      25: col = 8'h4C;
      26: col = 8'h51;
      27: col = 8'h52;
      28: col = 8'h54;
      29: col = 8'h58;
      30: col = 8'h61;
      31: col = 8'h62;
      default: col = 8'h00;
    endcase
    return col;
  endfunction

  // Check bit k is the XOR of every data bit whose column has bit k set;
  // accumulating whole columns computes all eight parities at once.
  function automatic logic [ECC_W-1:0] gen_ecc(input logic [DATA_W-1:0] data);
    logic [ECC_W-1:0] ecc;
    logic [ECC_W-1:0] col;
    ecc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      col = h_col(i);
      if (data[i]) begin
        ecc = ecc ^ col;
      end
    end
    return ecc;
  endfunction

endpackage

// File: rtl/edc_lane_decode.sv
// edc_lane_decode -- combinational syndrome decoder for one 32-bit lane.
//
// Ports:
//   syndrome : regenerated check bits XOR stored check bits
//   flip     : data-bit correction mask (one-hot on a data-column match, else 0)
//   cls      : syn_class_e value (NONE / CORR_DATA / CORR_CHK / UNCORR)
module edc_lane_decode
  import edc_pkg::*;
(
  input  logic [ECC_W-1:0]  syndrome,
  output logic [DATA_W-1:0] flip,
  output logic [1:0]        cls
);

  logic [DATA_W-1:0] match;

  // Columns are distinct, so at most one match bit can be set.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
      assign match[gi] = (syndrome == h_col(gi));
    end
  endgenerate

  always_comb begin
    cls  = CLS_UNCORR;
    flip = '0;
    if (syndrome == '0) begin
      cls = CLS_NONE;
    end else if (|match) begin
      cls  = CLS_CORR_DATA;
      flip = match;
    end else if ($onehot(syndrome)) begin
      // The stored check bit itself was hit; the data is already correct.
      cls = CLS_CORR_CHK;
    end
  end

endmodule

// File: rtl/edc_check_pipe.sv
// edc_check_pipe -- two-stage SEC-DED check/correct stage for the memory read
// path, NUM_LANES independent (40,32) lanes per beat.
//
// Stage 1 registers addr, raw data and per-lane syndromes; stage 2 registers
// corrected data and per-lane flags. Latency 2 cycles, 1 beat/cycle.
// Error counters and the first-uncorrectable-error log update on the output
// handshake.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_valid/o_ready        input beat handshake (o_ready is combinational)
//   i_addr, i_data, i_ecc  address tag, raw data, stored check bits
//   o_valid/i_ready        output beat handshake
//   o_addr, o_data         address tag, corrected data
//   o_err_lane/o_unc_lane  per-lane syndrome-nonzero / uncorrectable flags
//   i_cnt_clr              clears counters, log valid and scrub overflow
//   o_ce_count/o_ue_count  saturating correctable / uncorrectable counts
//   o_log_*                first uncorrectable event (addr, lane, syndrome)
//
// Optional build macro EDC_SCRUB_EN adds a one-entry scrub write-back buffer:
//   o_scrub_valid/i_scrub_ready, o_scrub_addr, o_scrub_data, o_scrub_ovf.
module edc_check_pipe
  import edc_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic [DATA_W*NUM_LANES-1:0] i_data,
  input  logic [ECC_W*NUM_LANES-1:0]  i_ecc,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W*NUM_LANES-1:0] o_data,
  output logic [NUM_LANES-1:0]        o_err_lane,
  output logic [NUM_LANES-1:0]        o_unc_lane,
  input  logic                        i_cnt_clr,
  output logic [CNT_W-1:0]            o_ce_count,
  output logic [CNT_W-1:0]            o_ue_count,
  output logic                        o_log_valid,
  output logic [ADDR_W-1:0]           o_log_addr,
  output logic [2:0]                  o_log_lane,
  output logic [7:0]                  o_log_syndrome
`ifdef EDC_SCRUB_EN
  ,
  output logic                        o_scrub_valid,
  input  logic                        i_scrub_ready,
  output logic [ADDR_W-1:0]           o_scrub_addr,
  output logic [DATA_W*NUM_LANES-1:0] o_scrub_data,
  output logic                        o_scrub_ovf
`endif
);

  localparam int DW    = DATA_W * NUM_LANES;
  localparam int EW    = ECC_W * NUM_LANES;
  // Headroom for adding up to 8 lanes' worth of events before saturating.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic adv1;
  logic adv2;
  logic out_hs;

  assign adv2    = !o_valid || i_ready;
  assign adv1    = !s1_valid || adv2;
  assign o_ready = adv1;
  assign out_hs  = o_valid && i_ready;

  // ------------------------------------------------------------------ stage 1
  logic [ADDR_W-1:0] s1_addr;
  logic [DW-1:0]     s1_data;
  logic [EW-1:0]     s1_syn;
  logic [EW-1:0]     syn_in;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_syn
      assign syn_in[gi*ECC_W +: ECC_W] =
        gen_ecc(i_data[gi*DATA_W +: DATA_W]) ^ i_ecc[gi*ECC_W +: ECC_W];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (adv1) begin
      s1_valid <= i_valid;
      s1_addr  <= i_addr;
      s1_data  <= i_data;
      s1_syn   <= syn_in;
    end
  end

  // ------------------------------------------------------- stage 2 decode
  logic [DW-1:0]        corr_data;
  logic [NUM_LANES-1:0] lane_err;
  logic [NUM_LANES-1:0] lane_unc;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] flip;
      logic [1:0]        cls;

      edc_lane_decode u_dec (
        .syndrome (s1_syn[gi*ECC_W +: ECC_W]),
        .flip     (flip),
        .cls      (cls)
      );

      // flip is zero for every class but CORR_DATA, so uncorrectable lanes
      // pass through raw.
      assign corr_data[gi*DATA_W +: DATA_W] = s1_data[gi*DATA_W +: DATA_W] ^ flip;
      assign lane_err[gi] = (cls != CLS_NONE);
      assign lane_unc[gi] = (cls == CLS_UNCORR);
    end
  endgenerate

  // Stage-2 syndromes are kept only so the log can record them.
  logic [EW-1:0] s2_syn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_err_lane <= '0;
      o_unc_lane <= '0;
      s2_syn     <= '0;
    end else if (adv2) begin
      o_valid    <= s1_valid;
      o_addr     <= s1_addr;
      o_data     <= corr_data;
      o_err_lane <= lane_err;
      o_unc_lane <= lane_unc;
      s2_syn     <= s1_syn;
    end
  end

  // ------------------------------------------------- event tally of stage 2
  logic [3:0]       ce_n;
  logic [3:0]       ue_n;
  logic [2:0]       low_lane;
  logic [7:0]       low_syn;
  logic [SUM_W-1:0] ce_sum;
  logic [SUM_W-1:0] ue_sum;
  logic [CNT_W-1:0] ce_next;
  logic [CNT_W-1:0] ue_next;

  always_comb begin
    ce_n     = '0;
    ue_n     = '0;
    low_lane = '0;
    low_syn  = '0;
    // Walking downward leaves the lowest failing lane as the final capture.
    for (int n = NUM_LANES - 1; n >= 0; n--) begin
      if (o_err_lane[n] && !o_unc_lane[n]) begin
        ce_n = ce_n + 4'd1;
      end
      if (o_unc_lane[n]) begin
        ue_n     = ue_n + 4'd1;
        low_lane = 3'(n);
        low_syn  = s2_syn[n*ECC_W +: ECC_W];
      end
    end
  end

  always_comb begin
    ce_sum  = SUM_W'(o_ce_count) + SUM_W'(ce_n);
    ue_sum  = SUM_W'(o_ue_count) + SUM_W'(ue_n);
    ce_next = (ce_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ce_sum[CNT_W-1:0];
    ue_next = (ue_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ue_sum[CNT_W-1:0];
  end

  // --------------------------------------------------- counters and log
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ce_count     <= '0;
      o_ue_count     <= '0;
      o_log_valid    <= 1'b0;
      o_log_addr     <= '0;
      o_log_lane     <= '0;
      o_log_syndrome <= '0;
    end else if (i_cnt_clr) begin
      // Clear takes priority; events of a coinciding beat are dropped.
      o_ce_count  <= '0;
      o_ue_count  <= '0;
      o_log_valid <= 1'b0;
    end else if (out_hs) begin
      o_ce_count <= ce_next;
      o_ue_count <= ue_next;
      if (!o_log_valid && (ue_n != 4'd0)) begin
        o_log_valid    <= 1'b1;
        o_log_addr     <= o_addr;
        o_log_lane     <= low_lane;
        o_log_syndrome <= low_syn;
      end
    end
  end

`ifdef EDC_SCRUB_EN
  // ----------------------------------------------- scrub write-back buffer
  // Only fully repairable beats are worth writing back. A slot draining in
  // the same cycle counts as free, so back-to-back scrubs are not lost.
  logic scrub_qual;
  logic scrub_busy;

  assign scrub_qual = out_hs && (ce_n != 4'd0) && (ue_n == 4'd0);
  assign scrub_busy = o_scrub_valid && !i_scrub_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scrub_valid <= 1'b0;
      o_scrub_addr  <= '0;
      o_scrub_data  <= '0;
      o_scrub_ovf   <= 1'b0;
    end else begin
      if (scrub_qual && !scrub_busy) begin
        o_scrub_valid <= 1'b1;
        o_scrub_addr  <= o_addr;
        o_scrub_data  <= o_data;
      end else if (i_scrub_ready) begin
        o_scrub_valid <= 1'b0;
      end

      if (i_cnt_clr) begin
        o_scrub_ovf <= 1'b0;
      end else if (scrub_qual && scrub_busy) begin
        o_scrub_ovf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_edc_check_pipe.sv
// tb_edc_check_pipe -- directed plus random bench for edc_check_pipe
// (NUM_LANES=2, CNT_W=2, default build). The reference model tracks which
// bits were injected into each lane and derives the expected data, flags,
// syndrome and counts from the error count per lane.
module tb_edc_check_pipe;
  import edc_pkg::*;

  localparam int NL    = 2;
  localparam int AW    = 32;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [AW-1:0]     i_addr;
  logic [32*NL-1:0]  i_data;
  logic [8*NL-1:0]   i_ecc;
  logic              o_valid;
  logic              i_ready;
  logic [AW-1:0]     o_addr;
  logic [32*NL-1:0]  o_data;
  logic [NL-1:0]     o_err_lane;
  logic [NL-1:0]     o_unc_lane;
  logic              i_cnt_clr;
  logic [CW-1:0]     o_ce_count;
  logic [CW-1:0]     o_ue_count;
  logic              o_log_valid;
  logic [AW-1:0]     o_log_addr;
  logic [2:0]        o_log_lane;
  logic [7:0]        o_log_syndrome;

  edc_check_pipe #(.NUM_LANES(NL), .ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .i_ecc          (i_ecc),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_addr         (o_addr),
    .o_data         (o_data),
    .o_err_lane     (o_err_lane),
    .o_unc_lane     (o_unc_lane),
    .i_cnt_clr      (i_cnt_clr),
    .o_ce_count     (o_ce_count),
    .o_ue_count     (o_ue_count),
    .o_log_valid    (o_log_valid),
    .o_log_addr     (o_log_addr),
    .o_log_lane     (o_log_lane),
    .o_log_syndrome (o_log_syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [32*NL-1:0] data;
    logic [NL-1:0]    err;
    logic [NL-1:0]    unc;
    logic [2:0]       lane;
    logic [7:0]       syn;
    int               ce;
    int               ue;
  } exp_t;

  exp_t     q[$];
  exp_t     p_exp;
  int       n_tests = 0;
  int       n_fail  = 0;

  // Model state: stage occupancy, counters, log.
  bit         m_s1, m_s2;
  int         m_ce, m_ue;
  bit         m_log_v;
  logic [31:0] m_log_addr;
  logic [2:0]  m_log_lane;
  logic [7:0]  m_log_syn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Syndrome contribution of a single flipped position (0..31 data, 32..39 check).
  function automatic logic [7:0] pos_col(input int p);
    logic [7:0] one;
    one = 8'h01;
    if (p < 32) return h_col(p);
    return one << (p - 32);
  endfunction

  // Build a beat from random clean words with the listed positions flipped
  // (-1 = unused) and record what the block must produce for it.
  task automatic prep(input logic [31:0] addr, input int f0a, input int f0b,
                      input int f1a, input int f1b);
    int fl [NL][2];
    fl[0][0] = f0a; fl[0][1] = f0b; fl[1][0] = f1a; fl[1][1] = f1b;
    p_exp.addr = addr; p_exp.ce = 0; p_exp.ue = 0;
    p_exp.err = '0; p_exp.unc = '0; p_exp.lane = '0; p_exp.syn = '0;
    i_addr = addr;
    for (int l = NL - 1; l >= 0; l--) begin
      logic [31:0] clean, raw;
      logic [7:0]  ecc, syn;
      int          nf;
      clean = $urandom;
      raw = clean; ecc = gen_ecc(clean); syn = '0; nf = 0;
      for (int j = 0; j < 2; j++) begin
        if (fl[l][j] >= 0) begin
          nf++;
          syn = syn ^ pos_col(fl[l][j]);
          if (fl[l][j] < 32) raw[fl[l][j]] = ~raw[fl[l][j]];
          else ecc[fl[l][j]-32] = ~ecc[fl[l][j]-32];
        end
      end
      i_data[32*l +: 32] = raw;
      i_ecc[8*l +: 8]    = ecc;
      p_exp.data[32*l +: 32] = (nf == 2) ? raw : clean;
      p_exp.err[l] = (nf > 0);
      p_exp.unc[l] = (nf == 2);
      if (nf == 1) p_exp.ce++;
      if (nf == 2) begin
        p_exp.ue++;
        p_exp.lane = 3'(l);
        p_exp.syn  = syn;
      end
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // One clock: drive, compare outputs against the model, advance the model.
  task automatic cycle(input bit v, input bit rdy, input bit clr);
    exp_t e;
    bit   a1, a2;
    i_valid = v; i_ready = rdy; i_cnt_clr = clr;
    #1;
    a2 = !m_s2 || rdy;
    a1 = !m_s1 || a2;
    chk("o_valid", o_valid, m_s2);
    chk("o_ready", o_ready, a1);
    chk("ce_count", o_ce_count, m_ce);
    chk("ue_count", o_ue_count, m_ue);
    chk("log_valid", o_log_valid, m_log_v);
    if (m_log_v) begin
      chk("log_addr", o_log_addr, m_log_addr);
      chk("log_lane", o_log_lane, m_log_lane);
      chk("log_syn", o_log_syndrome, m_log_syn);
    end
    if (m_s2 && q.size() > 0) begin
      e = q[0];
      chk("o_addr", o_addr, e.addr);
      chk("o_data", o_data, e.data);
      chk("o_err_lane", o_err_lane, e.err);
      chk("o_unc_lane", o_unc_lane, e.unc);
    end
    if (m_s2 && rdy && q.size() > 0) begin
      e = q.pop_front();
      if (!clr) begin
        m_ce = sat(m_ce + e.ce);
        m_ue = sat(m_ue + e.ue);
        if (!m_log_v && e.ue > 0) begin
          m_log_v = 1'b1; m_log_addr = e.addr; m_log_lane = e.lane; m_log_syn = e.syn;
        end
      end
    end
    if (clr) begin
      m_ce = 0; m_ue = 0; m_log_v = 1'b0;
    end
    if (v && a1) q.push_back(p_exp);
    if (a2) m_s2 = m_s1;
    if (a1) m_s1 = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send();
    cycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bit pending;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    i_addr = '0; i_data = '0; i_ecc = '0;
    m_s1 = 0; m_s2 = 0; m_ce = 0; m_ue = 0; m_log_v = 0;
    m_log_addr = '0; m_log_lane = '0; m_log_syn = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_ce", o_ce_count, 0);
    chk("rst_ue", o_ue_count, 0);
    chk("rst_log_valid", o_log_valid, 0);
    chk("rst_o_data", o_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean beats back to back.
    for (int i = 0; i < 4; i++) begin
      prep(32'h100 + i, -1, -1, -1, -1);
      send();
    end
    drain();
    chk("clean_ce", o_ce_count, 0);

    // Lane 1 data bit 17.
    prep(32'h1000, -1, -1, 17, -1);
    send();
    drain();
    chk("sbe_ce", o_ce_count, 1);

    // Two double errors; the log keeps the first.
    prep(32'h2040, 3, 9, -1, -1);
    send();
    prep(32'h3000, -1, -1, 5, 20);
    send();
    drain();
    chk("dbe_ue", o_ue_count, 2);
    chk("dbe_log_addr", o_log_addr, 32'h2040);
    chk("dbe_log_lane", o_log_lane, 0);
    chk("dbe_log_syn", o_log_syndrome, 8'h12);

    // Check bit 4 of lane 0.
    prep(32'h4000, 36, -1, -1, -1);
    send();
    drain();
    chk("chk_ce", o_ce_count, 2);

    // Downstream stalled for 5 cycles with 3 beats offered.
    prep(32'h5000, -1, -1, -1, -1);
    cycle(1'b1, 1'b0, 1'b0);
    prep(32'h5001, -1, -1, -1, -1);
    cycle(1'b1, 1'b0, 1'b0);
    prep(32'h5002, -1, -1, -1, -1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("stall_ready", o_ready, 0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    drain();

    // Saturation, then clear together with a further correctable event.
    prep(32'h6000, 1, -1, -1, -1);
    send();
    drain();
    chk("sat_ce_a", o_ce_count, 3);
    prep(32'h6004, -1, -1, 30, -1);
    send();
    drain();
    chk("sat_ce_b", o_ce_count, 3);
    prep(32'h6008, 12, -1, -1, -1);
    send();
    for (int i = 0; i < 8 && !m_s2; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("clr_ce", o_ce_count, 0);
    chk("clr_ue", o_ue_count, 0);
    chk("clr_log", o_log_valid, 0);

    // Random traffic, back-pressure and occasional clears.
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit v, rdy, clr, acc;
      int f [4];
      v   = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      clr = ($urandom_range(39) == 0);
      if (!pending) begin
        for (int l = 0; l < NL; l++) begin
          int k, a;
          k = $urandom_range(3);
          a = $urandom_range(39);
          f[2*l]   = (k == 0) ? -1 : a;
          f[2*l+1] = (k == 3) ? (a + 1 + $urandom_range(38)) % 40 : -1;
        end
        prep($urandom, f[0], f[1], f[2], f[3]);
      end
      acc = !m_s1 || !m_s2 || rdy;
      cycle(v || pending, rdy, clr);
      pending = (v || pending) && !acc;
    end
    drain();

    // Reset with beats in flight discards them.
    prep(32'h7000, 2, -1, -1, -1);
    send();
    prep(32'h7001, -1, -1, -1, -1);
    send();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ce", o_ce_count, 0);
    chk("mid_rst_log", o_log_valid, 0);
    q.delete();
    m_s1 = 0; m_s2 = 0; m_ce = 0; m_ue = 0; m_log_v = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
